// File: rtl/pemstat_upd_arb.sv
// MAC statistics update sequencer/arbiter: expands RX/TX stat vectors into counter
// read-modify-write cycles and serves host reads on one store port. Option macro: PEMSTAT_CLR_ON_RD_EN.
module pemstat_upd_arb #(
  parameter int unsigned CNT_W      = 31,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_vld_i,
  output logic              rx_rdy_o,
  input  logic [15:0]       rx_len_i,
  input  logic [3:0]        rx_flags_i,
  input  logic              tx_vld_i,
  output logic              tx_rdy_o,
  input  logic [15:0]       tx_len_i,
  input  logic [3:0]        tx_flags_i,
  input  logic              host_req_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic              host_ack_o,
  output logic [31:0]       host_rdata_o,
  output logic [ADDR_W-1:0] st_addr_o,
  output logic              st_rd_o,
  input  logic [CNT_W-1:0]  st_rdata_i,
  output logic              st_wr_o,
  output logic [CNT_W-1:0]  st_wdata_o,
  output logic              busy_o
);

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUPD    = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned OCT_IDX = 1;
  localparam int unsigned STV_W   = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] RX_BASE = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] TX_BASE = ADDR_W'(8'h10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VRD,
    S_VWR,
    S_HRD,
    S_HACK
`ifdef PEMSTAT_CLR_ON_RD_EN
    , S_HCLR
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [NUPD-1:0]    pend_q, pend_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               tx_q, tx_d;
  logic [STV_W-1:0]   starve_q, starve_d;

  logic [IDX_W-1:0]   upd_idx;
  logic [ADDR_W-1:0]  upd_addr;
  logic [CNT_W-1:0]   upd_inc;
  logic [NUPD-1:0]    pend_rest;
  logic               vec_req;
  logic               host_win;
  logic               unused_flag0;

  // Flag bit 0 carries no counter.
  assign unused_flag0 = rx_flags_i[0] ^ tx_flags_i[0];

  // Pending update bits: [0] frames, [1] octets, [2] mcast, [3] bcast, [4] errors; lowest goes next.
  always_comb begin
    upd_idx = '0;
    for (int i = NUPD - 1; i >= 0; i--) begin
      if (pend_q[i]) upd_idx = IDX_W'(i);
    end
  end

  assign upd_addr  = (tx_q ? TX_BASE : RX_BASE) + ADDR_W'(upd_idx);
  assign upd_inc   = (upd_idx == IDX_W'(OCT_IDX)) ? CNT_W'(len_q) : CNT_W'(1);
  assign pend_rest = pend_q & ~(NUPD'(1) << upd_idx);
  assign vec_req   = rx_vld_i | tx_vld_i;
  assign host_win  = host_req_i & (~vec_req | (starve_q == STV_W'(STARVE_MAX)));

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    len_d        = len_q;
    tx_d         = tx_q;
    starve_d     = starve_q;
    rx_rdy_o     = 1'b0;
    tx_rdy_o     = 1'b0;
    host_ack_o   = 1'b0;
    host_rdata_o = '0;
    st_addr_o    = '0;
    st_rd_o      = 1'b0;
    st_wr_o      = 1'b0;
    st_wdata_o   = '0;
    busy_o       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (host_win) begin
          starve_d = '0;
          state_d  = S_HRD;
        end else if (vec_req) begin
          rx_rdy_o = rx_vld_i;
          tx_rdy_o = ~rx_vld_i;
          tx_d     = ~rx_vld_i;
          len_d    = rx_vld_i ? rx_len_i : tx_len_i;
          pend_d   = {(rx_vld_i ? rx_flags_i[3:1] : tx_flags_i[3:1]), 2'b11};
          if (host_req_i) starve_d = starve_q + STV_W'(1);
          state_d  = S_VRD;
        end
      end
      S_VRD: begin
        st_rd_o   = 1'b1;
        st_addr_o = upd_addr;
        state_d   = S_VWR;
      end
      S_VWR: begin
        st_wr_o    = 1'b1;
        st_addr_o  = upd_addr;
        st_wdata_o = st_rdata_i + upd_inc;
        pend_d     = pend_rest;
        state_d    = (pend_rest == '0) ? S_IDLE : S_VRD;
      end
      S_HRD: begin
        st_rd_o   = 1'b1;
        st_addr_o = host_addr_i;
`ifdef PEMSTAT_CLR_ON_RD_EN
        state_d   = S_HCLR;
`else
        state_d   = S_HACK;
`endif
      end
      S_HACK: begin
        host_ack_o   = 1'b1;
        host_rdata_o = DATA_W'(st_rdata_i);
        state_d      = S_IDLE;
      end
`ifdef PEMSTAT_CLR_ON_RD_EN
      // Return the pre-clear value while zeroing the counter in the same cycle.
      S_HCLR: begin
        st_wr_o      = 1'b1;
        st_addr_o    = host_addr_i;
        st_wdata_o   = '0;
        host_ack_o   = 1'b1;
        host_rdata_o = DATA_W'(st_rdata_i);
        state_d      = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      len_q    <= '0;
      tx_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      len_q    <= len_d;
      tx_q     <= tx_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_pemstat_upd_arb.sv
// Bench for pemstat_upd_arb: counter store model, per-vector expected-write list,
// host-read checks against a reference counter array, plus directed literal cases.
module tb_pemstat_upd_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_vld, rx_rdy, tx_vld, tx_rdy;
  logic [15:0] rx_len, tx_len;
  logic [3:0]  rx_flags, tx_flags;
  logic        host_req, host_ack;
  logic [5:0]  host_addr, st_addr;
  logic [31:0] host_rdata;
  logic        st_rd, st_wr, busy;
  logic [30:0] st_rdata, st_wdata;

  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [30:0] pl_data;

  bit   [30:0] mem [64];
  bit   [30:0] ref_mem [64];
  logic [5:0]  exp_a [$];
  logic [30:0] exp_v [$];
  logic [5:0]  wr_log [$];
  int          gr_cyc [$];

  int total = 0, bad = 0, cyc = 0;
  int rx_gr = 0, tx_gr = 0, wr_cnt = 0, rx_rdy_cyc = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  pemstat_upd_arb #(.CNT_W(31), .ADDR_W(6), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_vld_i(rx_vld), .rx_rdy_o(rx_rdy), .rx_len_i(rx_len), .rx_flags_i(rx_flags),
    .tx_vld_i(tx_vld), .tx_rdy_o(tx_rdy), .tx_len_i(tx_len), .tx_flags_i(tx_flags),
    .host_req_i(host_req), .host_addr_i(host_addr), .host_ack_o(host_ack), .host_rdata_o(host_rdata),
    .st_addr_o(st_addr), .st_rd_o(st_rd), .st_rdata_i(st_rdata), .st_wr_o(st_wr),
    .st_wdata_o(st_wdata), .busy_o(busy)
  );

  // Single-port counter RAM: read data appears the cycle after st_rd.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (st_wr) mem[st_addr] <= st_wdata;
    if (st_rd) st_rdata <= mem[st_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected store writes for one accepted vector, in update-list order.
  task automatic push_vec(input bit tx, input logic [15:0] len, input logic [3:0] fl);
    for (int k = 0; k < 5; k++) begin
      logic [5:0]  a;
      logic [30:0] inc;
      if (k >= 2 && !fl[k-1]) continue;
      a   = (tx ? 6'h10 : 6'h00) + 6'(k);
      inc = (k == 1) ? 31'(len) : 31'd1;
      exp_a.push_back(a);
      exp_v.push_back(ref_mem[a] + inc);
    end
  endtask

  task automatic compare_loop();
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_a.delete();
        exp_v.delete();
        chk("reset_ctrl", 64'({rx_rdy, tx_rdy, host_ack, st_addr, st_rd, st_wr, busy}), 64'd0);
        chk("reset_data", 64'({host_rdata, st_wdata}), 64'd0);
      end else begin
        if (pl_en) ref_mem[pl_addr] = pl_data;
        if (st_wr) begin
          wr_cnt++;
          wr_log.push_back(st_addr);
          chk("wr_expected", 64'(exp_a.size() != 0), 64'd1);
          if (exp_a.size() != 0) begin
            chk("wr_addr", 64'(st_addr), 64'(exp_a[0]));
            chk("wr_data", 64'(st_wdata), 64'(exp_v[0]));
            ref_mem[exp_a[0]] = exp_v[0];
            void'(exp_a.pop_front());
            void'(exp_v.pop_front());
          end
        end
        if (host_ack) begin
          chk("ack_no_pending_wr", 64'(exp_a.size()), 64'd0);
          chk("host_rdata", 64'(host_rdata), 64'({1'b0, ref_mem[host_addr]}));
        end
        if (rx_rdy) rx_rdy_cyc++;
        if (rx_rdy || tx_rdy) begin
          chk("rdy_onehot", 64'(rx_rdy && tx_rdy), 64'd0);
          if (rx_vld) chk("rx_priority", 64'(rx_rdy), 64'd1);
        end
        if (rx_vld && rx_rdy) begin
          rx_gr++;
          gr_cyc.push_back(cyc);
          push_vec(1'b0, rx_len, rx_flags);
        end else if (tx_vld && tx_rdy) begin
          tx_gr++;
          push_vec(1'b1, tx_len, tx_flags);
        end
      end
    end
  endtask

  // Drivers are entered and left just after a rising edge.
  task automatic send_rx(input logic [15:0] len, input logic [3:0] fl);
    int n = 0;
    rx_vld = 1'b1; rx_len = len; rx_flags = fl;
    do begin @(negedge clk); n++; end while (!rx_rdy && n < 300);
    if (!rx_rdy) chk("rx_rdy_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rx_vld = 1'b0;
  endtask

  task automatic send_tx(input logic [15:0] len, input logic [3:0] fl);
    int n = 0;
    tx_vld = 1'b1; tx_len = len; tx_flags = fl;
    do begin @(negedge clk); n++; end while (!tx_rdy && n < 300);
    if (!tx_rdy) chk("tx_rdy_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    tx_vld = 1'b0;
  endtask

  task automatic host_read(input logic [5:0] a, output logic [31:0] d, output int lat);
    lat = 0; d = '0;
    host_req = 1'b1; host_addr = a;
    @(negedge clk);
    while (!host_ack && lat < 300) begin lat++; @(negedge clk); end
    if (!host_ack) chk("host_ack_timeout", 64'd0, 64'd1);
    else d = host_rdata;
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 300);
    chk("idle_timeout", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [30:0] v);
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_tests();
    logic [31:0] d;
    int lat, w0, w1, r0, g0, q0, ng, mism;
    bit found;
    logic [5:0]  ea [7];
    logic [30:0] tv [5];
    ea = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14};
    tv = '{31'd1, 31'd1518, 31'd1, 31'd1, 31'd1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ctrl_outputs", 64'({rx_rdy, tx_rdy, host_ack, st_rd, st_wr, st_addr}), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    w0 = wr_cnt; r0 = rx_rdy_cyc;
    send_rx(16'd64, 4'b0000);
    wait_idle();
    chk("basic_frames", 64'(mem[0]), 64'd1);
    chk("basic_octets", 64'(mem[1]), 64'd64);
    chk("basic_wr_count", 64'(wr_cnt - w0), 64'd2);
    chk("basic_rdy_cycles", 64'(rx_rdy_cyc - r0), 64'd1);

    w0 = wr_log.size();
    fork
      send_rx(16'd10, 4'b0000);
      send_tx(16'd1518, 4'b1110);
    join
    wait_idle();
    chk("contend_wr_count", 64'(wr_log.size() - w0), 64'd7);
    if (wr_log.size() - w0 == 7)
      for (int i = 0; i < 7; i++) chk("contend_wr_order", 64'(wr_log[w0+i]), 64'(ea[i]));
    for (int i = 0; i < 5; i++) chk("contend_tx_cnt", 64'(mem[16+i]), 64'(tv[i]));

    g0 = rx_gr; q0 = gr_cyc.size(); ng = 0;
    fork
      begin host_read(6'h10, d, lat); ng = rx_gr - g0; end
      for (int i = 0; i < 10; i++) send_rx(16'd1, 4'b0000);
    join
    wait_idle();
    chk("starve_grants", 64'(ng), 64'd8);
    chk("starve_rdata", 64'(d), 64'd1);
    if (gr_cyc.size() > q0 + 1) chk("vec_grant_spacing", 64'(gr_cyc[q0+1] - gr_cyc[q0]), 64'd5);
    else chk("vec_grant_spacing_seen", 64'd0, 64'd1);

    host_read(6'h11, d, lat);
    chk("hread_rdata", 64'(d), 64'd1518);
    chk("hread_latency", 64'(lat), 64'd2);

    preload(6'h01, 31'h7FFF_FFF0);
    send_rx(16'd32, 4'b0000);
    wait_idle();
    chk("wrap_octets", 64'(mem[1]), 64'h10);

    send_rx(16'd5, 4'b0000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (st_rd && st_addr == 6'h01) found = 1'b1;
    end
    chk("midrst_octet_rd_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({rx_rdy, tx_rdy, host_ack, st_addr, st_rd, st_wr, busy}), 64'd0);
    chk("midrst_data", 64'({host_rdata, st_wdata}), 64'd0);
    w1 = wr_cnt;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("midrst_no_write", 64'(wr_cnt - w1), 64'd0);
    chk("midrst_octets_kept", 64'(mem[1]), 64'h10);

    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send_rx(16'($urandom), 4'($urandom));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send_tx(16'($urandom), 4'($urandom));
      end
      for (int i = 0; i < 12; i++) begin
        logic [31:0] hd;
        int hl;
        repeat ($urandom_range(0, 8)) begin @(posedge clk); #1; end
        host_read(6'($urandom), hd, hl);
      end
    join
    wait_idle();
    chk("rand_queue_drained", 64'(exp_a.size()), 64'd0);
    mism = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != ref_mem[i]) mism++;
    chk("rand_store_vs_model", 64'(mism), 64'd0);
  endtask

  initial begin
    rx_vld = 1'b0; rx_len = '0; rx_flags = '0;
    tx_vld = 1'b0; tx_len = '0; tx_flags = '0;
    host_req = 1'b0; host_addr = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    st_rdata = '0;
    fork
      compare_loop();
      begin run_tests(); done = 1'b1; end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
